adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  NREQ  per-requester operation request.
REQ-005 req_a  in  NREQ*32  operand A; slice i = bits [32*i+31:32*i].
REQ-006 req_b  in  NREQ*32  operand B; same slicing as req_a.
REQ-007 req_cin  in  NREQ  per-requester carry-in.
REQ-008 req_ready  out  NREQ  accept strobe, one-hot or zero.
REQ-009 rsp_valid  out  1  result available.
REQ-010 rsp_ready  in  1  consumer accepts result.
REQ-011 rsp_id  out  clog2(NREQ)  index of requester that owns the result.
REQ-012 rsp_sum  out  32  A+B+cin modulo 2^32.
REQ-013 rsp_cout  out  1  carry out of bit 31.

Function
REQ-014 Shall time-share one 32-bit carry-lookahead adder among NREQ requesters.
REQ-015 FSM states: IDLE, CALC, HOLD; any other encoding shall return to IDLE next cycle.
REQ-016 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally that cycle, capture its a/b/cin/id into operand registers, go CALC; else stay IDLE.
REQ-017 req_ready shall be asserted only in IDLE, for at most one bit.
REQ-018 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant updates on every accept.
REQ-019 CALC: register adder sum/cout and rsp_id, set rsp_valid, go HOLD; always exactly one cycle.
REQ-020 Latency: accept in cycle T, rsp_valid high from cycle T+2.
REQ-021 HOLD: rsp_sum/rsp_cout/rsp_id stable while rsp_valid and not rsp_ready; on rsp_valid and rsp_ready, clear rsp_valid, go IDLE.
REQ-022 Throughput: at most one accept per 3 cycles; no new accept while HOLD stalls.
REQ-023 Requesters shall hold req_valid and operands until req_ready; the block need not tolerate withdrawal.
REQ-024 req_valid changes during CALC/HOLD shall have no effect until next IDLE.

Reset
REQ-025 While rst high at a clock edge: state IDLE, last_grant = NREQ-1 (requester 0 wins first), rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, operand registers 0.
REQ-026 req_ready shall be 0 in any cycle rst is high.
REQ-027 Reset in CALC or HOLD shall discard the in-flight operation; no response produced.

Configuration
REQ-028 Macro ADDER_ARB_STATS_EN.
REQ-029 Defined: extra output stat_grants, NREQ*16 bits; slice i counts accepts of requester i, saturates at 0xFFFF, cleared by rst.
REQ-030 Undefined: stat_grants port and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package adder_arbiter_pkg: DATA_W=32, STAT_W=16, FSM state typedef.
REQ-032 One sub-module: existing adder_32bit instance fed from operand registers; carry-in applied as A+B+cin with cout taken from the 33-bit result path, no second adder.
REQ-033 Arbiter priority logic inline; no further sub-modules.

Verification
REQ-034 Reset: rst high 2 cycles, all req_valid high -> req_ready=0, rsp_valid=0, rsp_sum=0 during reset; first grant after release = requester 0.
REQ-035 Single op: req1 a=0xFFFFFFFF b=0x00000001 cin=0 -> req_ready[1] at T, rsp_valid at T+2, rsp_sum=0x00000000, rsp_cout=1, rsp_id=1.
REQ-036 Carry-in: req0 a=0x7FFFFFFF b=0x00000001 cin=1 -> rsp_sum=0x80000001, rsp_cout=0.
REQ-037 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1, accepts spaced 3 cycles.
REQ-038 Backpressure/reset: rsp_ready low 5 cycles -> outputs stable, no req_ready; rst asserted in CALC -> rsp_valid stays 0, next grant requester 0.
REQ-039 ADDER_ARB_STATS_EN: 70000 accepts to requester 2 -> stat_grants slice 2 = 0xFFFF, others 0.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared widths and FSM state type for adder_arbiter
package adder_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/adder_32bit.sv
// rtl/adder_32bit.sv - 32-bit carry-lookahead adder, 4-bit groups with group generate/propagate
module adder_32bit
  import adder_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W:0]   c;
  logic              gg;
  logic              gp;

  // Group carries skip across each 4-bit block; only the inner bits ripple.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    gp   = 1'b0;
    for (int blk = 0; blk < DATA_W / 4; blk++) begin
      gg = g[4*blk+3]
         | (p[4*blk+3] & g[4*blk+2])
         | (p[4*blk+3] & p[4*blk+2] & g[4*blk+1])
         | (p[4*blk+3] & p[4*blk+2] & p[4*blk+1] & g[4*blk]);
      gp = &p[4*blk+3 -: 4];
      for (int j = 0; j < 3; j++) begin
        c[4*blk+j+1] = g[4*blk+j] | (p[4*blk+j] & c[4*blk+j]);
      end
      c[4*blk+4] = gg | (gp & c[4*blk]);
    end
  end

  assign sum  = p ^ c[DATA_W-1:0];
  assign cout = c[DATA_W];

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter time-sharing one 32-bit adder among NREQ requesters
// Optional grant statistics counters enabled by defining ADDER_ARB_STATS_EN.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_sum,
  output logic                     rsp_cout
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]   stat_grants
`endif
);

  localparam int ID_W = $clog2(NREQ);

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_any;
  logic              accept;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_cin;
  logic [ID_W-1:0]   op_id;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  int                idx;

  // Scan farthest-to-nearest from last_grant so the nearest valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign accept    = (state == IDLE) && grant_any && !rst;
  assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    state_next = HOLD;
      HOLD:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  adder_32bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NREQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_cin     <= 1'b0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= grant_id;
        op_a       <= req_a[int'(grant_id)*DATA_W +: DATA_W];
        op_b       <= req_b[int'(grant_id)*DATA_W +: DATA_W];
        op_cin     <= req_cin[grant_id];
        op_id      <= grant_id;
      end
      if (state == CALC) begin
        rsp_sum   <= add_sum;
        rsp_cout  <= add_cout;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == HOLD && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else if (accept && (grant_cnt[grant_id] != '1)) begin
      grant_cnt[grant_id] <= grant_cnt[grant_id] + STAT_W'(1);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NREQ; i++) stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed table-driven bench for adder_arbiter
module tb_adder_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_cin;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
  logic         rsp_cout;
`ifdef ADDER_ARB_STATS_EN
  logic [63:0]  stat_grants;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int w;
    @(posedge clk); #1;
    req_valid           = '0;
    req_valid[v.id]     = 1'b1;
    req_a[32*v.id +: 32] = v.a;
    req_b[32*v.id +: 32] = v.b;
    req_cin[v.id]       = v.cin;
    rsp_ready           = 1'b1;
    @(negedge clk);
    w = 0;
    while (req_ready == 4'b0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("op_ready", {60'b0, req_ready}, 64'(4'b0001 << v.id));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("op_t1_valid", {63'b0, rsp_valid}, 0);
    @(negedge clk);
    chk("op_t2_valid", {63'b0, rsp_valid}, 1);
    chk("op_sum", {32'b0, rsp_sum}, {32'b0, v.sum});
    chk("op_cout", {63'b0, rsp_cout}, {63'b0, v.cout});
    chk("op_id", {62'b0, rsp_id}, 64'(v.id));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g_id [6];
    int g_cyc [6];
    int exp_ids [6];
    int ng;

    exp_ids = '{0, 1, 2, 3, 0, 1};
    vecs[0] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0};
    vecs[2] = '{2, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
    vecs[4] = '{2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[5] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{3, 32'hDEAD_BEEF, 32'h2152_4110, 1'b0, 32'hFFFF_FFFF, 1'b0};

    // Reset with every requester asking, then round-robin fairness.
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = {32'd40, 32'd30, 32'd20, 32'd10};
    req_b     = {32'd4, 32'd3, 32'd2, 32'd1};
    req_cin   = 4'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {60'b0, req_ready}, 0);
      chk("rst_rsp_valid", {63'b0, rsp_valid}, 0);
      chk("rst_rsp_sum", {32'b0, rsp_sum}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ng = 0;
    for (int cyc = 0; cyc < 17; cyc++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        chk("rr_onehot", {63'b0, $onehot(req_ready)}, 1);
        if (ng < 6) begin
          g_cyc[ng] = cyc;
          g_id[ng]  = 0;
          for (int b = 0; b < 4; b++) if (req_ready[b]) g_id[ng] = b;
        end
        ng++;
      end
    end
    chk("rr_count", 64'(ng), 6);
    if (ng > 0) chk("rr_first_cycle", 64'(g_cyc[0]), 0);
    for (int i = 0; i < 6 && i < ng; i++) begin
      chk("rr_order", 64'(g_id[i]), 64'(exp_ids[i]));
      if (i > 0) chk("rr_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 3);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    foreach (vecs[i]) do_op(vecs[i]);
    repeat (2) @(posedge clk);

    // Backpressure: response held stable for 5 stalled cycles, no grants.
    @(posedge clk); #1;
    req_valid        = 4'b0100;
    req_a[64 +: 32]  = 32'h10;
    req_b[64 +: 32]  = 32'h20;
    req_cin[2]       = 1'b0;
    rsp_ready        = 1'b0;
    @(negedge clk);
    chk("bp_ready", {60'b0, req_ready}, 64'h4);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", {63'b0, rsp_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {63'b0, rsp_valid}, 1);
      chk("bp_hold_sum", {32'b0, rsp_sum}, 64'h30);
      chk("bp_hold_id", {62'b0, rsp_id}, 2);
      chk("bp_hold_ready", {60'b0, req_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", {63'b0, rsp_valid}, 1);
    @(negedge clk);
    chk("bp_after_valid", {63'b0, rsp_valid}, 0);
    chk("bp_after_ready", {60'b0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // Reset while in CALC discards the operation and restarts priority at 0.
    @(posedge clk); #1;
    req_valid        = 4'b0010;
    req_a[32 +: 32]  = 32'h5;
    req_b[32 +: 32]  = 32'h6;
    @(negedge clk);
    chk("rc_ready", {60'b0, req_ready}, 64'h2);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rc_calc_ready", {60'b0, req_ready}, 0);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rc_no_rsp", {63'b0, rsp_valid}, 0);
    chk("rc_grant0", {60'b0, req_ready}, 64'h1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("rc_no_rsp2", {63'b0, rsp_valid}, 0);
    repeat (4) @(posedge clk);

`ifdef ADDER_ARB_STATS_EN
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    repeat (70000 * 3 + 6) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stat_req0", {48'b0, stat_grants[15:0]}, 0);
    chk("stat_req1", {48'b0, stat_grants[31:16]}, 0);
    chk("stat_req2", {48'b0, stat_grants[47:32]}, 64'hFFFF);
    chk("stat_req3", {48'b0, stat_grants[63:48]}, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
